// File: rtl/move_dispatcher.sv
// move_dispatcher: front end of the board validator.
// Latches one move request, reads source/destination pieces, rejects trivially
// illegal moves, otherwise launches the matching per-piece checker and returns
// its verdict (or a timeout) over a valid/ready response handshake.
// Optional build macro: KING_CAPTURE_CHECK_EN (reject any move onto a king, code 7).
module move_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            old_x,
    input  logic [2:0]            old_y,
    input  logic [2:0]            new_x,
    input  logic [2:0]            new_y,
    input  logic                  side,
    input  logic [7:0][7:0][3:0]  board_in,
    output logic [5:0]            chk_sel,
    output logic                  chk_start,
    output logic [2:0]            chk_old_x,
    output logic [2:0]            chk_old_y,
    output logic [2:0]            chk_new_x,
    output logic [2:0]            chk_new_y,
    output logic [2:0]            chk_h_delta,
    output logic [2:0]            chk_v_delta,
    output logic [3:0]            chk_piece_type,
    input  logic                  chk_done,
    input  logic                  chk_valid_move,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_legal,
    output logic [2:0]            rsp_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SQ_W  = 3;
    localparam int unsigned PC_W  = 4;
    localparam int unsigned SEL_W = 6;

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_NULL   = 3'd1;
    localparam logic [2:0] ERR_EMPTY  = 3'd2;
    localparam logic [2:0] ERR_SIDE   = 3'd3;
    localparam logic [2:0] ERR_OWN    = 3'd4;
    localparam logic [2:0] ERR_REJECT = 3'd5;
    localparam logic [2:0] ERR_TMO    = 3'd6;
`ifdef KING_CAPTURE_CHECK_EN
    localparam logic [2:0] ERR_KING   = 3'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PRECHECK, S_DISPATCH, S_WAIT, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic [SQ_W-1:0]   ox_q, ox_d, oy_q, oy_d, nx_q, nx_d, ny_q, ny_d;
    logic [SQ_W-1:0]   h_q, h_d, v_q, v_d;
    logic              side_q, side_d;
    logic [PC_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              legal_q, legal_d;
    logic [2:0]        err_q, err_d;
    logic [2:0]        pre_err;

    function automatic logic [SQ_W-1:0] abs_diff(input logic [SQ_W-1:0] a, input logic [SQ_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic is_empty(input logic [2:0] kind);
        return (kind == 3'd0) || (kind == 3'd7);
    endfunction

    function automatic logic [SEL_W-1:0] sel_of(input logic [2:0] kind);
        case (kind)
            3'd1:    return 6'b000001;
            3'd2:    return 6'b000010;
            3'd3:    return 6'b000100;
            3'd4:    return 6'b001000;
            3'd5:    return 6'b010000;
            3'd6:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    // Precheck verdict in priority order; ERR_OK means dispatch to a checker.
    always_comb begin
        pre_err = ERR_OK;
        if ((ox_q == nx_q) && (oy_q == ny_q))
            pre_err = ERR_NULL;
        else if (is_empty(src_q[2:0]))
            pre_err = ERR_EMPTY;
        else if (src_q[3] != side_q)
            pre_err = ERR_SIDE;
        else if (!is_empty(dst_q[2:0]) && (dst_q[3] == src_q[3]))
            pre_err = ERR_OWN;
`ifdef KING_CAPTURE_CHECK_EN
        else if (dst_q[2:0] == 3'd6)
            pre_err = ERR_KING;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            ox_q        <= '0;
            oy_q        <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            h_q         <= '0;
            v_q         <= '0;
            side_q      <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            sel_q       <= '0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            legal_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            h_q         <= h_d;
            v_q         <= v_d;
            side_q      <= side_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            legal_q     <= legal_d;
            err_q       <= err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        h_d         = h_q;
        v_d         = v_q;
        side_d      = side_q;
        src_d       = src_q;
        dst_d       = dst_q;
        sel_d       = sel_q;
        start_d     = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        legal_d     = legal_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ox_d        = old_x;
                    oy_d        = old_y;
                    nx_d        = new_x;
                    ny_d        = new_y;
                    side_d      = side;
                    req_ready_d = 1'b0;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                src_d   = board_in[oy_q][ox_q];
                dst_d   = board_in[ny_q][nx_q];
                h_d     = abs_diff(nx_q, ox_q);
                v_d     = abs_diff(ny_q, oy_q);
                state_d = S_PRECHECK;
            end
            S_PRECHECK: begin
                if (pre_err != ERR_OK) begin
                    rsp_valid_d = 1'b1;
                    legal_d     = 1'b0;
                    err_d       = pre_err;
                    state_d     = S_RESP;
                end else begin
                    sel_d   = sel_of(src_q[2:0]);
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A verdict arriving on the final counted cycle still beats the timeout.
                if (chk_done) begin
                    rsp_valid_d = 1'b1;
                    legal_d     = chk_valid_move;
                    err_d       = chk_valid_move ? ERR_OK : ERR_REJECT;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    legal_d     = 1'b0;
                    err_d       = ERR_TMO;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    sel_d       = '0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                sel_d       = '0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready      = req_ready_q;
    assign chk_sel        = sel_q;
    assign chk_start      = start_q;
    assign chk_old_x      = ox_q;
    assign chk_old_y      = oy_q;
    assign chk_new_x      = nx_q;
    assign chk_new_y      = ny_q;
    assign chk_h_delta    = h_q;
    assign chk_v_delta    = v_q;
    assign chk_piece_type = src_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_legal      = legal_q;
    assign rsp_err        = err_q;

endmodule

// File: tb/tb_move_dispatcher.sv
// Scoreboard bench for move_dispatcher: stimulus queues expected checker
// launches and responses; a checker model and a response monitor pop and compare.
module tb_move_dispatcher;

    logic                 clk;
    logic                 reset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic                 side;
    logic [7:0][7:0][3:0] board_in;
    logic [5:0]           chk_sel;
    logic                 chk_start;
    logic [2:0]           chk_old_x, chk_old_y, chk_new_x, chk_new_y;
    logic [2:0]           chk_h_delta, chk_v_delta;
    logic [3:0]           chk_piece_type;
    logic                 chk_done;
    logic                 chk_valid_move;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_legal;
    logic [2:0]           rsp_err;

    move_dispatcher #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .side(side), .board_in(board_in),
        .chk_sel(chk_sel), .chk_start(chk_start),
        .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
        .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta),
        .chk_piece_type(chk_piece_type),
        .chk_done(chk_done), .chk_valid_move(chk_valid_move),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_legal(rsp_legal), .rsp_err(rsp_err)
    );

    typedef struct {
        logic       legal;
        logic [2:0] err;
        int         lat;
        int         bp;
    } rsp_exp_t;

    typedef struct {
        logic [5:0] sel;
        logic [2:0] h, v, ox, oy, nx, ny;
        logic [3:0] pc;
    } chk_exp_t;

    rsp_exp_t             rsp_q[$];
    chk_exp_t             chk_q[$];
    logic [7:0][7:0][3:0] board;
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;
    int                   acc_cyc = 0;
    int                   rsp_seen = 0;
    int                   cm_delay = -1;
    logic                 cm_verdict = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Checker model: verifies each launch, then answers after cm_delay cycles (-1 = never).
    initial begin
        chk_exp_t c;
        chk_done       = 1'b0;
        chk_valid_move = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && chk_start) begin
                if (chk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chk_start: got chk_sel %b expected no launch", chk_sel);
                end else begin
                    c = chk_q.pop_front();
                    check("chk_start_latency", cyc - acc_cyc, 3);
                    check("chk_sel", int'(chk_sel), int'(c.sel));
                    check("chk_h_delta", int'(chk_h_delta), int'(c.h));
                    check("chk_v_delta", int'(chk_v_delta), int'(c.v));
                    check("chk_old_x", int'(chk_old_x), int'(c.ox));
                    check("chk_old_y", int'(chk_old_y), int'(c.oy));
                    check("chk_new_x", int'(chk_new_x), int'(c.nx));
                    check("chk_new_y", int'(chk_new_y), int'(c.ny));
                    check("chk_piece_type", int'(chk_piece_type), int'(c.pc));
                    if (cm_delay >= 0) begin
                        repeat (cm_delay) @(negedge clk);
                        check("chk_sel_held", int'(chk_sel), int'(c.sel));
                        chk_done       = 1'b1;
                        chk_valid_move = cm_verdict;
                        @(negedge clk);
                        chk_done       = 1'b0;
                        chk_valid_move = 1'b0;
                    end
                end
            end
        end
    end

    // Response monitor: compares against the queue, applies backpressure, then consumes.
    initial begin
        rsp_exp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got err %0d expected no response", rsp_err);
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_latency", cyc - acc_cyc, e.lat);
                    check("rsp_legal", int'(rsp_legal), int'(e.legal));
                    check("rsp_err", int'(rsp_err), int'(e.err));
                    check("req_ready_busy", int'(req_ready), 0);
                    for (int i = 0; i < e.bp; i++) begin
                        @(negedge clk);
                        check("bp_rsp_valid", int'(rsp_valid), 1);
                        check("bp_rsp_legal", int'(rsp_legal), int'(e.legal));
                        check("bp_rsp_err", int'(rsp_err), int'(e.err));
                        check("bp_req_ready", int'(req_ready), 0);
                    end
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    check("post_rsp_req_ready", int'(req_ready), 1);
                    check("post_rsp_valid", int'(rsp_valid), 0);
                    check("post_rsp_chk_sel", int'(chk_sel), 0);
                    rsp_seen++;
                end
            end
        end
    end

    task automatic send_req(input logic [2:0] ox, input logic [2:0] oy,
                            input logic [2:0] nx, input logic [2:0] ny, input logic sd);
        @(negedge clk);
        check("req_ready_idle", int'(req_ready), 1);
        board_in  = board;
        old_x     = ox;
        old_y     = oy;
        new_x     = nx;
        new_y     = ny;
        side      = sd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic run_move(input logic [2:0] ox, input logic [2:0] oy,
                            input logic [2:0] nx, input logic [2:0] ny, input logic sd,
                            input logic legal, input logic [2:0] err, input int lat, input int bp,
                            input logic disp, input logic [5:0] sel, input logic [2:0] h,
                            input logic [2:0] v, input logic [3:0] pc,
                            input int delay, input logic verdict);
        rsp_exp_t r;
        chk_exp_t c;
        int       seen0;
        int       t;
        r.legal = legal;
        r.err   = err;
        r.lat   = lat;
        r.bp    = bp;
        rsp_q.push_back(r);
        if (disp) begin
            c.sel = sel; c.h = h; c.v = v;
            c.ox = ox; c.oy = oy; c.nx = nx; c.ny = ny; c.pc = pc;
            chk_q.push_back(c);
        end
        cm_delay   = delay;
        cm_verdict = verdict;
        seen0      = rsp_seen;
        send_req(ox, oy, nx, ny, sd);
        if (bp > 0) begin
            // Requests offered while the response is stalled must be ignored.
            repeat (3) @(posedge clk);
            #1 req_valid = 1'b1;
            repeat (4) @(posedge clk);
            #1 req_valid = 1'b0;
        end
        t = 0;
        while (rsp_seen == seen0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("rsp_completed", rsp_seen - seen0, 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        old_x = '0; old_y = '0; new_x = '0; new_y = '0;
        side      = 1'b0;
        board     = '0;
        board_in  = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_chk_sel", int'(chk_sel), 0);
        check("reset_chk_start", int'(chk_start), 0);
        check("reset_rsp_err", int'(rsp_err), 0);
        check("reset_chk_h_delta", int'(chk_h_delta), 0);
        reset_n = 1'b1;

        // Knight launch and legal verdict.
        board = '0;
        board[0][1] = 4'h2;
        run_move(1, 0, 2, 2, 0, 1, 3'd0, 6, 0, 1, 6'b000010, 1, 2, 4'h2, 2, 1);
        // Knight rejected by checker.
        run_move(1, 0, 1, 1, 0, 0, 3'd5, 4, 0, 1, 6'b000010, 0, 1, 4'h2, 0, 0);
        // Wrong side: black to move, white knight.
        run_move(1, 0, 2, 2, 1, 0, 3'd3, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
        // Null move, occupied and empty source (null has priority).
        board[4][4] = 4'h5;
        run_move(4, 4, 4, 4, 0, 0, 3'd1, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
        run_move(3, 3, 3, 3, 0, 0, 3'd1, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
        // Empty source, and type 7 treated as empty.
        run_move(3, 3, 3, 4, 0, 0, 3'd2, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
        board[2][2] = 4'hF;
        run_move(2, 2, 3, 3, 0, 0, 3'd2, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);

        // Own capture versus enemy capture.
        board = '0;
        board[0][0] = 4'h4;
        board[1][0] = 4'h1;
        run_move(0, 0, 0, 1, 0, 0, 3'd4, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
        board[1][0] = 4'h9;
        run_move(0, 0, 0, 1, 0, 1, 3'd0, 7, 0, 1, 6'b001000, 0, 1, 4'h4, 3, 1);

        // Timeout, verdict on the final counted cycle, verdict one cycle earlier.
        board[1][0] = 4'h0;
        run_move(0, 0, 0, 5, 0, 0, 3'd6, 18, 0, 1, 6'b001000, 0, 5, 4'h4, -1, 0);
        run_move(0, 0, 0, 5, 0, 1, 3'd0, 18, 0, 1, 6'b001000, 0, 5, 4'h4, 14, 1);
        run_move(0, 0, 0, 5, 0, 0, 3'd5, 17, 0, 1, 6'b001000, 0, 5, 4'h4, 13, 0);

        // Black bishop capturing toward lower coordinates; white pawn and king.
        board = '0;
        board[7][2] = 4'hB;
        board[4][5] = 4'h1;
        run_move(2, 7, 5, 4, 1, 0, 3'd5, 5, 0, 1, 6'b000100, 3, 3, 4'hB, 1, 0);
        board[1][0] = 4'h1;
        run_move(0, 1, 0, 2, 0, 1, 3'd0, 4, 0, 1, 6'b000001, 0, 1, 4'h1, 0, 1);
        board[0][4] = 4'h6;
        run_move(4, 0, 5, 1, 0, 1, 3'd0, 4, 0, 1, 6'b100000, 1, 1, 4'h6, 0, 1);

        // Backpressure on a precheck reject.
        run_move(3, 3, 3, 4, 0, 0, 3'd2, 2, 10, 0, 6'b0, 0, 0, 4'h0, -1, 0);

        // Reset while waiting for the checker, then a normal move.
        board = '0;
        board[0][1] = 4'h2;
        begin
            chk_exp_t c;
            c.sel = 6'b000010; c.h = 1; c.v = 2;
            c.ox = 1; c.oy = 0; c.nx = 2; c.ny = 2; c.pc = 4'h2;
            chk_q.push_back(c);
        end
        cm_delay = -1;
        send_req(1, 0, 2, 2, 0);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midreset_req_ready", int'(req_ready), 1);
        check("midreset_rsp_valid", int'(rsp_valid), 0);
        check("midreset_chk_sel", int'(chk_sel), 0);
        check("midreset_chk_start", int'(chk_start), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_move(1, 0, 2, 2, 0, 1, 3'd0, 5, 0, 1, 6'b000010, 1, 2, 4'h2, 1, 1);

        // White queen onto the black king.
        board = '0;
        board[0][3] = 4'h5;
        board[7][3] = 4'hE;
`ifdef KING_CAPTURE_CHECK_EN
        run_move(3, 0, 3, 7, 0, 0, 3'd7, 2, 0, 0, 6'b0, 0, 0, 4'h0, -1, 0);
`else
        run_move(3, 0, 3, 7, 0, 1, 3'd0, 5, 0, 1, 6'b010000, 0, 7, 4'h5, 1, 1);
`endif

        repeat (5) @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("chk_queue_drained", chk_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
